// File: rtl/fu_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | fu_ctrl_pkg : shared types and sizing helpers for fu_occupancy_ctrl   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package fu_ctrl_pkg;

  localparam int MAX_LAT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } mem_state_t;

  function automatic int lat_bits(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  localparam int LAT_BITS_DEF = $clog2(MAX_LAT_DEF + 1);

endpackage

`default_nettype wire

// File: rtl/fu_busy_counter.sv
// +----------------------------------------------------------------------+
// | fu_busy_counter : per-ALU occupancy counter with flush kill pulse     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module fu_busy_counter import fu_ctrl_pkg::*; #(
  parameter int MAX_LAT  = MAX_LAT_DEF,
  parameter int LAT_BITS = lat_bits(MAX_LAT)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic [LAT_BITS-1:0] issue_lat_i,
  output logic                idle_o,
  output logic                kill_o,
  output logic                issue_err_o
);

  localparam logic [LAT_BITS-1:0] c_lat_max = LAT_BITS'(MAX_LAT);
  localparam logic [LAT_BITS-1:0] c_one     = LAT_BITS'(1);

  logic [LAT_BITS-1:0] cnt_q, cnt_d;
  logic [LAT_BITS-1:0] w_lat_eff;

  always_comb begin
    w_lat_eff = issue_lat_i;
    if (issue_lat_i == '0) begin
      w_lat_eff = c_one;
    end else if (issue_lat_i > c_lat_max) begin
      w_lat_eff = c_lat_max;
    end
  end

  assign idle_o      = (cnt_q == '0);
  assign kill_o      = flush_i && !idle_o;
  assign issue_err_o = issue_valid_i && !flush_i && !idle_o;

  // An issue to a busy unit is rejected, so it never reloads the count.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (!idle_o) begin
      cnt_d = cnt_q - c_one;
    end else if (issue_valid_i) begin
      cnt_d = w_lat_eff - c_one;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fu_occupancy_ctrl.sv
// +----------------------------------------------------------------------+
// | fu_occupancy_ctrl : ALU/MEM/branch occupancy tracking and flush kill  |
// | Optional busy-cycle counters under macro FU_OCC_PERF_EN. Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module fu_occupancy_ctrl import fu_ctrl_pkg::*; #(
  parameter int  NUM_ALU    = 2,
  parameter int  NUM_MEM    = 1,
  parameter int  NUM_BRANCH = 1,
  parameter int  MAX_LAT    = MAX_LAT_DEF,
  localparam int LAT_BITS   = lat_bits(MAX_LAT)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NUM_ALU-1:0]           alu_issue_valid_i,
  input  logic [LAT_BITS*NUM_ALU-1:0]  alu_issue_lat_i,
  input  logic [NUM_MEM-1:0]           mem_issue_valid_i,
  input  logic [NUM_MEM-1:0]           mem_resp_valid_i,
  input  logic [NUM_BRANCH-1:0]        branch_issue_valid_i,
  input  logic [NUM_BRANCH-1:0]        branch_ready_i,
  output logic [NUM_ALU-1:0]           alu_available_o,
  output logic [NUM_MEM-1:0]           mem_available_o,
  output logic [NUM_BRANCH-1:0]        branch_available_o,
  output logic [NUM_ALU-1:0]           alu_kill_o,
  output logic [NUM_MEM-1:0]           mem_wb_en_o,
`ifdef FU_OCC_PERF_EN
  output logic [32*(NUM_ALU+NUM_MEM)-1:0] busy_cycles_o,
`endif
  output logic                         issue_err_o
);

  logic [NUM_ALU-1:0] w_alu_idle;
  logic [NUM_ALU-1:0] w_alu_err;
  logic [NUM_MEM-1:0] w_mem_idle;
  logic [NUM_MEM-1:0] w_mem_err;
  logic [NUM_BRANCH-1:0] w_br_err;
  logic err_q, err_d;

  for (genvar a = 0; a < NUM_ALU; a++) begin : g_alu
    fu_busy_counter #(
      .MAX_LAT  (MAX_LAT),
      .LAT_BITS (LAT_BITS)
    ) u_cnt (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .issue_valid_i (alu_issue_valid_i[a]),
      .issue_lat_i   (alu_issue_lat_i[a*LAT_BITS +: LAT_BITS]),
      .idle_o        (w_alu_idle[a]),
      .kill_o        (alu_kill_o[a]),
      .issue_err_o   (w_alu_err[a])
    );
    assign alu_available_o[a] = w_alu_idle[a] && !flush_i && rst_ni;
  end

  for (genvar m = 0; m < NUM_MEM; m++) begin : g_mem
    mem_state_t state_q, state_d;
    logic       w_wb;
    logic       w_err;

    // A response arriving alongside a flush retires the access but is squashed.
    always_comb begin
      state_d = state_q;
      w_wb    = 1'b0;
      w_err   = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_resp_valid_i[m]) w_err = 1'b1;
          if (mem_issue_valid_i[m] && !flush_i) state_d = BUSY;
        end
        BUSY: begin
          if (mem_issue_valid_i[m] && !flush_i) w_err = 1'b1;
          if (mem_resp_valid_i[m]) begin
            state_d = IDLE;
            w_wb    = !flush_i;
          end else if (flush_i) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (mem_issue_valid_i[m] && !flush_i) w_err = 1'b1;
          if (mem_resp_valid_i[m]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    assign w_mem_idle[m]      = (state_q == IDLE);
    assign w_mem_err[m]       = w_err;
    assign mem_wb_en_o[m]     = w_wb;
    assign mem_available_o[m] = w_mem_idle[m] && !flush_i && rst_ni;
  end

  assign branch_available_o = branch_ready_i & {NUM_BRANCH{!flush_i && rst_ni}};
  assign w_br_err           = branch_issue_valid_i & ~branch_ready_i & {NUM_BRANCH{!flush_i}};

  assign err_d = err_q || (|w_alu_err) || (|w_mem_err) || (|w_br_err);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign issue_err_o = err_q;

`ifdef FU_OCC_PERF_EN
  logic [NUM_ALU+NUM_MEM-1:0] w_unit_busy;
  assign w_unit_busy = {~w_mem_idle, ~w_alu_idle};

  for (genvar u = 0; u < NUM_ALU + NUM_MEM; u++) begin : g_perf
    logic [31:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (w_unit_busy[u] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign busy_cycles_o[u*32 +: 32] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fu_occupancy_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_fu_occupancy_ctrl : directed scoreboard bench for fu_occupancy_ctrl|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fu_occupancy_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic [1:0] alu_issue_valid_i;
  logic [7:0] alu_issue_lat_i;
  logic       mem_issue_valid_i;
  logic       mem_resp_valid_i;
  logic       branch_issue_valid_i;
  logic       branch_ready_i;
  logic [1:0] alu_available_o;
  logic       mem_available_o;
  logic       branch_available_o;
  logic [1:0] alu_kill_o;
  logic       mem_wb_en_o;
  logic       issue_err_o;
`ifdef FU_OCC_PERF_EN
  logic [95:0] busy_cycles_o;
`endif

  typedef struct packed {
    logic [1:0] alu;
    logic       mem;
    logic       br;
    logic [1:0] kill;
    logic       wb;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_vec    = 0;

  always #5 clk_i = ~clk_i;

  fu_occupancy_ctrl u_dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .flush_i              (flush_i),
    .alu_issue_valid_i    (alu_issue_valid_i),
    .alu_issue_lat_i      (alu_issue_lat_i),
    .mem_issue_valid_i    (mem_issue_valid_i),
    .mem_resp_valid_i     (mem_resp_valid_i),
    .branch_issue_valid_i (branch_issue_valid_i),
    .branch_ready_i       (branch_ready_i),
    .alu_available_o      (alu_available_o),
    .mem_available_o      (mem_available_o),
    .branch_available_o   (branch_available_o),
    .alu_kill_o           (alu_kill_o),
    .mem_wb_en_o          (mem_wb_en_o),
`ifdef FU_OCC_PERF_EN
    .busy_cycles_o        (busy_cycles_o),
`endif
    .issue_err_o          (issue_err_o)
  );

  task automatic chk(input string nm, input int vec, input logic [1:0] act, input logic [1:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %b expected %b", nm, vec, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a response, check it against the oldest expectation.
  int mon_vec = 0;
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("alu_available",    mon_vec, alu_available_o,             e.alu);
      chk("mem_available",    mon_vec, {1'b0, mem_available_o},     {1'b0, e.mem});
      chk("branch_available", mon_vec, {1'b0, branch_available_o},  {1'b0, e.br});
      chk("alu_kill",         mon_vec, alu_kill_o,                  e.kill);
      chk("mem_wb_en",        mon_vec, {1'b0, mem_wb_en_o},         {1'b0, e.wb});
      chk("issue_err",        mon_vec, {1'b0, issue_err_o},         {1'b0, e.err});
      mon_vec++;
    end
  end

  task automatic cyc(input logic fl, input logic [1:0] aiv, input logic [3:0] l0, input logic [3:0] l1,
                     input logic miv, input logic mr, input logic biv, input logic brdy,
                     input logic [1:0] ea, input logic em, input logic eb, input logic [1:0] ek,
                     input logic ew, input logic ee);
    exp_t e;
    flush_i              = fl;
    alu_issue_valid_i    = aiv;
    alu_issue_lat_i      = {l1, l0};
    mem_issue_valid_i    = miv;
    mem_resp_valid_i     = mr;
    branch_issue_valid_i = biv;
    branch_ready_i       = brdy;
    e.alu = ea; e.mem = em; e.br = eb; e.kill = ek; e.wb = ew; e.err = ee;
    exp_q.push_back(e);
    n_vec++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic [1:0] ea, input logic em, input logic ee);
    cyc(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, ea, em, 1'b1, 2'b00, 1'b0, ee);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cyc(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0; alu_issue_valid_i = '0; alu_issue_lat_i = '0;
    mem_issue_valid_i = 1'b0; mem_resp_valid_i = 1'b0;
    branch_issue_valid_i = 1'b0; branch_ready_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset held: every availability forced low.
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0);
    rst_ni = 1'b1;
    idle(2'b11, 1, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 2'b00, 0, 0);

    // ALU0 lat 4: busy three cycles.
    cyc(0, 2'b01, 4, 0, 0, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    repeat (3) idle(2'b10, 1, 0);
    idle(2'b11, 1, 0);

    // ALU1 lat 6 killed by flush two cycles later.
    cyc(0, 2'b10, 0, 6, 0, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    idle(2'b01, 1, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b10, 0, 0);
    idle(2'b11, 1, 0);

    // Issues during a flush are ignored entirely.
    cyc(1, 2'b11, 4, 4, 1, 0, 1, 1, 2'b00, 0, 0, 2'b00, 0, 0);
    idle(2'b11, 1, 0);

    // Latency 0 and 1 are single-cycle; back-to-back issue is legal.
    cyc(0, 2'b01, 0, 0, 0, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    cyc(0, 2'b10, 0, 1, 0, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    cyc(0, 2'b10, 0, 1, 0, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    idle(2'b11, 1, 0);

    // Latency 15 clamps to 8: busy seven cycles.
    cyc(0, 2'b10, 0, 15, 0, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    repeat (7) idle(2'b01, 1, 0);
    idle(2'b11, 1, 0);

    // Mem: issue, flush -> DRAIN, squashed response.
    cyc(0, 2'b00, 0, 0, 1, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0);
    repeat (3) idle(2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b11, 0, 1, 2'b00, 0, 0);
    idle(2'b11, 1, 0);

    // Mem: normal response writes back.
    cyc(0, 2'b00, 0, 0, 1, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    repeat (2) idle(2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b11, 0, 1, 2'b00, 1, 0);
    idle(2'b11, 1, 0);

    // Mem: flush and response together in BUSY.
    cyc(0, 2'b00, 0, 0, 1, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0);
    idle(2'b11, 1, 0);

    // Legal branch issue.
    cyc(0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    idle(2'b11, 1, 0);

    // ALU0 re-issue while busy: error, no reload.
    cyc(0, 2'b01, 3, 0, 0, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    cyc(0, 2'b01, 3, 0, 0, 0, 0, 1, 2'b10, 1, 1, 2'b00, 0, 0);
    idle(2'b10, 1, 1);
    idle(2'b11, 1, 1);
    idle(2'b11, 1, 1);

    // Mem response in IDLE: error.
    do_reset();
    idle(2'b11, 1, 0);
    cyc(0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    idle(2'b11, 1, 1);
    idle(2'b11, 1, 1);

    // Branch issue while not ready: error.
    do_reset();
    idle(2'b11, 1, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b11, 1, 0, 2'b00, 0, 0);
    idle(2'b11, 1, 1);

    // Mem issue while BUSY: error, outstanding access still completes.
    do_reset();
    cyc(0, 2'b00, 0, 0, 1, 0, 0, 1, 2'b11, 1, 1, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 0, 0, 1, 2'b11, 0, 1, 2'b00, 0, 0);
    idle(2'b11, 0, 1);
    cyc(0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b11, 0, 1, 2'b00, 1, 1);
    idle(2'b11, 1, 1);

    repeat (3) @(posedge clk_i);
    n_assert++;
    if (exp_q.size() != 0 || mon_vec != n_vec) begin
      n_fail++;
      $display("FAIL drain: %0d of %0d expectations checked", mon_vec, n_vec);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fu_occupancy_ctrl.md
Name: fu_occupancy_ctrl

Overview:
- Tracks occupancy of every execution unit: ALUs, the memory unit and the branch unit.
- Drives the per-unit availability vectors that the issue stage consumes each cycle.
- ALUs can run multi-cycle ops (mul/div); the memory unit is variable-latency behind a request/response handshake.
- Sits between the issue stage and the execution units; owns flush-time kill/squash of in-flight work.

Parameters:
- NUM_ALU, 2, number of ALU units
- NUM_MEM, 1, number of memory units
- NUM_BRANCH, 1, number of branch units
- MAX_LAT, 8, max ALU latency in cycles; LAT_BITS = $clog2(MAX_LAT+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (mispredict/exception)
- alu_issue_valid  in  NUM_ALU  op issued to ALU a this cycle
- alu_issue_lat  in  LAT_BITS x NUM_ALU  latency of issued op; 0 treated as 1, >MAX_LAT clamped to MAX_LAT
- mem_issue_valid  in  NUM_MEM  op issued to memory unit m
- mem_resp_valid  in  NUM_MEM  memory unit m completed its access
- branch_issue_valid  in  NUM_BRANCH  op issued to branch unit b
- branch_ready  in  NUM_BRANCH  branch unit can accept an op
- alu_available  out  NUM_ALU  ALU a may be issued to this cycle
- mem_available  out  NUM_MEM  memory unit m may be issued to
- branch_available  out  NUM_BRANCH  branch unit b may be issued to
- alu_kill  out  NUM_ALU  one-cycle pulse: abort in-flight multi-cycle op
- mem_wb_en  out  NUM_MEM  response may write back (not squashed)
- issue_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst low, async): all ALU counters 0, mem FSMs IDLE, issue_err 0, alu_kill 0. While rst is low, all *_available outputs are 0.
- ALU counter cnt[a]:
  - Issue with lat L>1 and no flush: cnt loads L-1 at the next edge.
  - Issue with L==1: cnt stays 0; the unit is fully pipelined for single-cycle ops.
  - cnt>0: decrements each cycle.
  - alu_available[a] = (cnt==0) && !flush. Combinational from state; no input-to-output path except flush.
- MEM FSM per unit (IDLE, BUSY, DRAIN):
  - IDLE + issue -> BUSY.
  - BUSY + resp -> IDLE, mem_wb_en=1 that cycle.
  - BUSY + flush (no resp) -> DRAIN.
  - BUSY + flush + resp same cycle -> IDLE, mem_wb_en=0.
  - DRAIN + resp -> IDLE, mem_wb_en=0 (squashed).
  - mem_available[m] = (state==IDLE) && !flush.
  - An access in DRAIN cannot be aborted; the unit stays unavailable until resp.
- Branch: branch_available[b] = branch_ready[b] && !flush. No internal state.
- Flush:
  - All ALU counters with cnt>0 clear to 0 at the next edge, and alu_kill[a] pulses for exactly the flush cycle for each such ALU.
  - Issues presented in a flush cycle are ignored, so no state change results from them.
- Protocol errors set issue_err, which stays set until reset. The offending event itself is ignored:
  - issue to an ALU whose cnt>0
  - issue to a mem unit not in IDLE
  - issue to a branch unit with branch_ready low
  - mem_resp_valid while in IDLE
- Simultaneous last-cycle and new issue: when cnt==1, the unit is still unavailable that cycle; availability returns the next cycle.

Optional Feature:
- Macro FU_OCC_PERF_EN.
- When defined:
  - Adds output busy_cycles (32 bits x (NUM_ALU+NUM_MEM)).
  - Each counter increments every cycle its unit is unavailable for internal-state reasons (ALU cnt>0, mem BUSY/DRAIN), saturating at all-ones.
  - Counters clear on reset only.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package fu_ctrl_pkg: mem_state_t enum {IDLE, BUSY, DRAIN}, MAX_LAT default, LAT_BITS function/constant.
- Sub-module fu_busy_counter: one per ALU, containing the load/decrement/flush-clear counter plus its kill pulse; generated NUM_ALU times.
- Memory FSMs and branch gating stay inline.

Test Plan:
- Reset release, no issue -> alu_available=2'b11, mem_available=1, branch_available=branch_ready. With rst low, all three are 0.
- Issue ALU0 lat=4 at cycle t -> alu_available[0]=0 for t+1..t+3, 1 at t+4. ALU1 stays 1 throughout.
- Issue ALU1 lat=6, flush at t+2 -> alu_kill[1]=1 only at t+2, alu_available[1]=1 at t+3, issue_err=0.
- Mem issue at t, flush at t+1, resp at t+5 -> mem_available=0 for t+1..t+5 (DRAIN t+2..t+5), mem_wb_en=0 at t+5, available at t+6.
- Mem issue at t, resp at t+3 -> mem_wb_en=1 at t+3 only. Flush and resp together in BUSY -> mem_wb_en=0, IDLE next cycle.
- Issue ALU0 lat=3 then issue again at t+1; separately, mem_resp in IDLE -> issue_err=1 and stays set. The second issue does not reload cnt (available at t+3).
